// File: rtl/sparse_tile_scheduler.sv
// Tile sequencer for sparse_core: fetches four weight rows per tile, clears and runs the core
// for CORE_LATENCY cycles, then writes the captured partial sums to the result buffer.
package sparse_tile_pkg;
  typedef struct packed {
    logic signed [7:0] val1;
    logic signed [7:0] val0;
    logic [1:0]        idx1;
    logic [1:0]        idx0;
  } sparse_packet_t;
  localparam int PSUM_W = 20;
endpackage

module sparse_tile_scheduler
  import sparse_tile_pkg::*;
#(
  parameter int NUM_TILES_MAX = 16,
  parameter int ADDR_W        = 10,
  parameter int CORE_LATENCY  = 4,
  localparam int TW           = $clog2(NUM_TILES_MAX)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cfg_start,
  input  logic                                cfg_abort,
  input  logic [TW:0]                         cfg_num_tiles,
  input  logic [ADDR_W-1:0]                   cfg_base_addr,
  output logic                                busy,
  output logic                                done,
  output logic                                err,
  output logic                                wmem_req,
  output logic [ADDR_W-1:0]                   wmem_addr,
  input  logic [$bits(sparse_packet_t)-1:0]   wmem_rdata,
  output logic                                core_clr,
  output logic                                core_en,
  output sparse_packet_t [3:0]                core_w_rows,
  input  logic signed [3:0][PSUM_W-1:0]       core_psum,
  output logic                                res_wr_en,
  output logic [TW-1:0]                       res_wr_addr,
  output logic [4*PSUM_W-1:0]                 res_wr_data,
  input  logic                                res_ready
);

  localparam int LW = (CORE_LATENCY > 1) ? $clog2(CORE_LATENCY) : 1;
  localparam logic [LW-1:0] LAT_LAST  = LW'(CORE_LATENCY - 1);
  localparam logic [TW:0]   MAX_TILES = (TW+1)'(NUM_TILES_MAX);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_WRITE   = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t              state_r, state_s;
  logic [TW-1:0]       tile_r, tile_s;
  logic [1:0]          row_r, row_s;
  logic [LW-1:0]       lat_r, lat_s;
  logic [TW:0]         num_r, num_s;
  logic [ADDR_W-1:0]   base_r, base_s;
  logic                err_r, err_s;
  logic                psum_cap_s;
  logic [TW:0]         tile_inc_s;
  logic [ADDR_W-1:0]   addr_s;

  logic                busy_r, done_r, wmem_req_r, core_clr_r, core_en_r, res_wr_en_r;
  logic [ADDR_W-1:0]   wmem_addr_r;
  logic [TW-1:0]       res_wr_addr_r;
  logic [4*PSUM_W-1:0] res_wr_data_r;
  sparse_packet_t [3:0] core_w_rows_r;
  logic                cap_vld_r;
  logic [1:0]          cap_row_r;

  // Next-state and counter logic; abort overrides every non-idle state
  always_comb begin
    state_s    = state_r;
    tile_s     = tile_r;
    row_s      = row_r;
    lat_s      = lat_r;
    num_s      = num_r;
    base_s     = base_r;
    err_s      = err_r;
    psum_cap_s = 1'b0;
    tile_inc_s = {1'b0, tile_r} + {{TW{1'b0}}, 1'b1};
    if (cfg_abort && (state_r != ST_IDLE)) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cfg_start) begin
            err_s  = 1'b0;
            tile_s = '0;
            row_s  = 2'd0;
            lat_s  = '0;
            if (cfg_num_tiles == '0) begin
              state_s = ST_DONE;
            end else if (cfg_num_tiles > MAX_TILES) begin
              err_s   = 1'b1;
              state_s = ST_DONE;
            end else begin
              num_s   = cfg_num_tiles;
              base_s  = cfg_base_addr;
              state_s = ST_FETCH;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_FETCH: begin
          if (row_r == 2'd3) begin
            row_s   = 2'd0;
            state_s = ST_LOAD;
          end else begin
            row_s = row_r + 2'd1;
          end
        end
        ST_LOAD: begin
          lat_s   = '0;
          state_s = ST_COMPUTE;
        end
        ST_COMPUTE: begin
          if (lat_r == LAT_LAST) begin
            psum_cap_s = 1'b1;
            state_s    = ST_WRITE;
          end else begin
            lat_s = lat_r + {{(LW-1){1'b0}}, 1'b1};
          end
        end
        ST_WRITE: begin
          if (res_ready) begin
            if (tile_inc_s < num_r) begin
              tile_s  = tile_inc_s[TW-1:0];
              row_s   = 2'd0;
              state_s = ST_FETCH;
            end else begin
              state_s = ST_DONE;
            end
          end else begin
            state_s = ST_WRITE;
          end
        end
        ST_DONE: state_s = ST_IDLE;
        default: state_s = ST_IDLE;
      endcase
    end
    // Address wraps modulo 2^ADDR_W by truncation
    addr_s = base_s + ADDR_W'({tile_s, 2'b00}) + ADDR_W'(row_s);
  end

  // State register and run context
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      tile_r  <= '0;
      row_r   <= 2'd0;
      lat_r   <= '0;
      num_r   <= '0;
      base_r  <= '0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      tile_r  <= tile_s;
      row_r   <= row_s;
      lat_r   <= lat_s;
      num_r   <= num_s;
      base_r  <= base_s;
      err_r   <= err_s;
    end
  end

  // Registered outputs decoded from the next state so they line up with it
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      wmem_req_r    <= 1'b0;
      wmem_addr_r   <= '0;
      core_clr_r    <= 1'b0;
      core_en_r     <= 1'b0;
      res_wr_en_r   <= 1'b0;
      res_wr_addr_r <= '0;
      res_wr_data_r <= '0;
      core_w_rows_r <= '0;
      cap_vld_r     <= 1'b0;
      cap_row_r     <= 2'd0;
    end else begin
      busy_r        <= (state_s != ST_IDLE);
      done_r        <= (state_s == ST_DONE);
      wmem_req_r    <= (state_s == ST_FETCH);
      wmem_addr_r   <= addr_s;
      core_clr_r    <= (state_s == ST_LOAD);
      core_en_r     <= (state_s == ST_COMPUTE);
      res_wr_en_r   <= (state_s == ST_WRITE);
      res_wr_addr_r <= tile_s;
      cap_vld_r     <= wmem_req_r;
      cap_row_r     <= row_r;
      if (psum_cap_s) begin
        res_wr_data_r <= core_psum;
      end else begin
        res_wr_data_r <= res_wr_data_r;
      end
      // Read data arrives one cycle after its request
      if (cap_vld_r) begin
        core_w_rows_r[cap_row_r] <= sparse_packet_t'(wmem_rdata);
      end else begin
        core_w_rows_r <= core_w_rows_r;
      end
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign err         = err_r;
  assign wmem_req    = wmem_req_r;
  assign wmem_addr   = wmem_addr_r;
  assign core_clr    = core_clr_r;
  assign core_en     = core_en_r;
  assign core_w_rows = core_w_rows_r;
  assign res_wr_en   = res_wr_en_r;
  assign res_wr_addr = res_wr_addr_r;
  assign res_wr_data = res_wr_data_r;

endmodule

// File: tb/tb_sparse_tile_scheduler.sv
// Directed bench for sparse_tile_scheduler with a weight memory, a behavioural core and a write scoreboard.
module tb_sparse_tile_scheduler;
  import sparse_tile_pkg::*;

  localparam int MAXT = 16;
  localparam int AW   = 10;
  localparam int LAT  = 4;
  localparam int TW   = 4;

  logic                      clk;
  logic                      rst;
  logic                      cfg_start;
  logic                      cfg_abort;
  logic [TW:0]               cfg_num_tiles;
  logic [AW-1:0]             cfg_base_addr;
  logic                      busy, done, err, wmem_req;
  logic [AW-1:0]             wmem_addr;
  logic [19:0]               wmem_rdata;
  logic                      core_clr, core_en;
  sparse_packet_t [3:0]      core_w_rows;
  logic signed [3:0][19:0]   core_psum;
  logic                      res_wr_en;
  logic [TW-1:0]             res_wr_addr;
  logic [79:0]               res_wr_data;
  logic                      res_ready;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [TW-1:0] addr;
    logic [79:0]   data;
  } wr_t;
  wr_t sb[$];

  sparse_packet_t mem [1024];
  logic signed [19:0] acc [4];

  sparse_tile_scheduler #(.NUM_TILES_MAX(MAXT), .ADDR_W(AW), .CORE_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_num_tiles(cfg_num_tiles), .cfg_base_addr(cfg_base_addr),
    .busy(busy), .done(done), .err(err), .wmem_req(wmem_req), .wmem_addr(wmem_addr),
    .wmem_rdata(wmem_rdata), .core_clr(core_clr), .core_en(core_en),
    .core_w_rows(core_w_rows), .core_psum(core_psum), .res_wr_en(res_wr_en),
    .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data), .res_ready(res_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic signed [19:0] pval(input sparse_packet_t p);
    int v;
    v = $signed(p.val0) * (int'(p.idx0) + 1) + $signed(p.val1) * (int'(p.idx1) + 1);
    return 20'(v);
  endfunction

  // Expected result word for a tile: LAT accumulations of each row's contribution
  function automatic logic [79:0] tile_exp(input int base, input int t);
    logic [79:0] d;
    int v;
    d = '0;
    for (int r = 0; r < 4; r++) begin
      v = LAT * int'(pval(mem[(base + 4 * t + r) % 1024]));
      d[r*20 +: 20] = 20'(v);
    end
    return d;
  endfunction

  // 1-cycle-latency weight memory
  always_ff @(posedge clk) begin
    if (wmem_req) wmem_rdata <= mem[wmem_addr];
  end

  // Behavioural core: accumulator with combinational look-ahead of the current term
  always_ff @(posedge clk) begin
    for (int r = 0; r < 4; r++) begin
      if (core_clr) acc[r] <= '0;
      else if (core_en) acc[r] <= acc[r] + pval(core_w_rows[r]);
    end
  end
  always_comb begin
    for (int r = 0; r < 4; r++)
      core_psum[r] = acc[r] + (core_en ? pval(core_w_rows[r]) : 20'sd0);
  end

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted write must match the oldest pending expectation
  always @(negedge clk) begin
    if (!rst && res_wr_en && res_ready) begin
      chk("sb_pending", 80'(sb.size() != 0), 80'(1));
      if (sb.size() != 0) begin
        wr_t e;
        e = sb.pop_front();
        chk("sb_addr", 80'(res_wr_addr), 80'(e.addr));
        chk("sb_data", res_wr_data, e.data);
      end
    end
  end

  // One run: cycle-exact schedule check; optional tile-0 stall and abort/reset at cycle kill_at
  task automatic run(input int base, input int cfg_n, input int stall, input int kill_at,
                     input bit kill_rst, input int exp_left, input bit with_abort);
    int n, last, t, p, cp;
    logic exp_err;
    n       = (cfg_n >= 1 && cfg_n <= MAXT) ? cfg_n : 0;
    exp_err = (cfg_n > MAXT);
    for (int i = 0; i < n; i++) sb.push_back('{addr: TW'(i), data: tile_exp(base, i)});
    cfg_num_tiles = (TW+1)'(cfg_n);
    cfg_base_addr = AW'(base);
    cfg_start = 1'b1;
    cfg_abort = with_abort;
    tick();
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    cfg_num_tiles = (TW+1)'($urandom);
    cfg_base_addr = AW'($urandom);
    last = 10 * n + 1 + stall;
    for (int c = 1; c <= last; c++) begin
      if (c >= 10 && c <= 10 + stall) begin
        t = 0; p = 9;
      end else begin
        cp = (c > 10 + stall) ? c - stall : c;
        t = (cp - 1) / 10;
        p = (cp - 1) % 10;
      end
      res_ready = !(c >= 10 && c < 10 + stall);
      chk("busy", 80'(busy), 80'(1));
      chk("err", 80'(err), 80'(exp_err));
      if (c == last) begin
        chk("done_pulse", 80'(done), 80'(1));
        chk("done_no_req", 80'(wmem_req), 80'(0));
        chk("done_no_wr", 80'(res_wr_en), 80'(0));
      end else begin
        chk("done_early", 80'(done), 80'(0));
        chk("wmem_req", 80'(wmem_req), 80'(p < 4));
        if (p < 4) chk("wmem_addr", 80'(wmem_addr), 80'((base + 4 * t + p) % 1024));
        chk("core_clr", 80'(core_clr), 80'(p == 4));
        chk("core_en", 80'(core_en), 80'(p >= 5 && p <= 8));
        chk("res_wr_en", 80'(res_wr_en), 80'(p == 9));
        if (p == 9) begin
          chk("res_wr_addr", 80'(res_wr_addr), 80'(t));
          chk("res_wr_data", res_wr_data, tile_exp(base, t));
        end
      end
      if (c == kill_at) begin
        if (kill_rst) rst = 1'b1;
        else cfg_abort = 1'b1;
        tick();
        rst = 1'b0;
        cfg_abort = 1'b0;
        res_ready = 1'b1;
        chk("kill_busy", 80'(busy), 80'(0));
        chk("kill_core_en", 80'(core_en), 80'(0));
        chk("kill_wr_en", 80'(res_wr_en), 80'(0));
        chk("kill_req", 80'(wmem_req), 80'(0));
        if (kill_rst) begin
          chk("rst_addr", 80'(wmem_addr), 80'(0));
          chk("rst_wdata", res_wr_data, 80'(0));
          chk("rst_waddr", 80'(res_wr_addr), 80'(0));
          chk("rst_rows", 80'(core_w_rows), 80'(0));
          chk("rst_clr", 80'(core_clr), 80'(0));
        end
        chk("kill_left", 80'(sb.size()), 80'(exp_left));
        sb.delete();
        for (int i = 0; i < 12; i++) begin
          tick();
          chk("kill_quiet_wr", 80'(res_wr_en), 80'(0));
          chk("kill_quiet_done", 80'(done), 80'(0));
        end
        return;
      end
      tick();
    end
    res_ready = 1'b1;
    chk("idle_busy", 80'(busy), 80'(0));
    chk("idle_done", 80'(done), 80'(0));
    chk("sb_drained", 80'(sb.size()), 80'(0));
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = sparse_packet_t'(20'($urandom));
    rst = 1'b1;
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    cfg_num_tiles = '0;
    cfg_base_addr = '0;
    res_ready = 1'b1;
    tick(); tick(); tick();
    chk("rst_busy", 80'(busy), 80'(0));
    chk("rst_done", 80'(done), 80'(0));
    chk("rst_err", 80'(err), 80'(0));
    chk("rst_req", 80'(wmem_req), 80'(0));
    chk("rst_en", 80'(core_en), 80'(0));
    chk("rst_wr_en", 80'(res_wr_en), 80'(0));
    chk("rst_rows0", 80'(core_w_rows), 80'(0));
    rst = 1'b0;
    tick();
    chk("post_rst_busy", 80'(busy), 80'(0));

    run(0,      1,  0, 0,  1'b0, 0, 1'b0);   // single tile
    run('h040,  3,  0, 0,  1'b0, 0, 1'b0);   // three tiles back to back
    run('h100,  2,  5, 0,  1'b0, 0, 1'b0);   // 5-cycle backpressure on tile 0
    run('h3FC,  2,  0, 0,  1'b0, 0, 1'b0);   // address wrap
    run(0,      0,  0, 0,  1'b0, 0, 1'b0);   // zero tiles
    run(0,      17, 0, 0,  1'b0, 0, 1'b0);   // oversize request sets err
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("err_sticky", 80'(err), 80'(1));
    end
    run('h200,  1,  0, 0,  1'b0, 0, 1'b0);   // valid start clears err
    run('h080,  2,  0, 17, 1'b0, 1, 1'b0);   // abort in tile 1 COMPUTE
    run('h010,  1,  0, 0,  1'b0, 0, 1'b0);   // normal run after abort
    run('h300,  2,  3, 11, 1'b1, 2, 1'b0);   // reset during stalled WRITE
    run('h0A0,  1,  0, 0,  1'b0, 0, 1'b1);   // start with abort in IDLE

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sparse_tile_scheduler.md
Name: sparse_tile_scheduler

Overview:
Sequencer that runs sparse_core over a programmable number of 4-row weight tiles without CPU involvement per tile. For each tile it fetches four sparse_packet_t rows from a 1-cycle-latency weight memory, clears the core and enables it for a fixed latency. It then captures the four partial sums and writes them to a result buffer, with backpressure. It sits between the AXI control registers (start/num_tiles/base) and the sparse_core datapath.

Parameters:
NUM_TILES_MAX, 16, maximum tiles per run; tile index width TW = $clog2(NUM_TILES_MAX)
ADDR_W, 10, weight memory address width (one sparse_packet_t per word)
CORE_LATENCY, 4, cycles core_en is held high per tile (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cfg_start  in  1  start pulse; sampled only in IDLE
cfg_abort  in  1  abort current run; ignored in IDLE
cfg_num_tiles  in  TW+1  tiles to process (0..NUM_TILES_MAX)
cfg_base_addr  in  ADDR_W  weight memory word address of tile 0, row 0
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of run
err  out  1  sticky: last start had cfg_num_tiles > NUM_TILES_MAX; cleared by next accepted start
wmem_req  out  1  weight read strobe
wmem_addr  out  ADDR_W  weight read address
wmem_rdata  in  $bits(sparse_packet_t)  read data, valid the cycle after wmem_req
core_clr  out  1  one-cycle accumulator clear to sparse_core
core_en  out  1  sparse_core enable
core_w_rows  out  4 x sparse_packet_t  registered weight rows for current tile
core_psum  in  4 x 20 signed  sparse_core partial sums
res_wr_en  out  1  result write valid
res_wr_addr  out  TW  tile index of result
res_wr_data  out  4 x 20  captured psums, row 0 in LSBs
res_ready  in  1  result buffer accepts when res_wr_en && res_ready

Behaviour:
- Reset: state=IDLE; busy, done, err, wmem_req, core_clr, core_en, res_wr_en = 0; wmem_addr, res_wr_addr, res_wr_data, core_w_rows, tile/row/latency counters = 0. Reset mid-run takes effect at the next edge, with no done pulse.
- States: IDLE, FETCH, LOAD, COMPUTE, WRITE, DONE.
- IDLE:
  - cfg_start with num_tiles in 1..MAX: latch num_tiles and base, tile=0, row=0, err<=0, go to FETCH.
  - num_tiles==0: go to DONE, no memory or core activity.
  - num_tiles > MAX: err<=1, go to DONE.
- FETCH, 4 cycles, row=0..3: wmem_req=1, wmem_addr = base + 4*tile + row, modulo 2^ADDR_W (wraps silently). Data for row r is captured into core_w_rows[r] on the cycle after its request. After row 3 is issued, go to LOAD.
- LOAD, 1 cycle: capture row 3; core_clr=1; go to COMPUTE.
- COMPUTE: core_en=1 for exactly CORE_LATENCY cycles; core_w_rows held stable. On exit, register core_psum into res_wr_data; go to WRITE.
- WRITE: res_wr_en=1, res_wr_addr=tile. Hold data and address stable until res_ready. On accept:
  - if tile+1 < num_tiles: tile++, row=0, go to FETCH;
  - else go to DONE.
- DONE, 1 cycle: done=1; return to IDLE.
- Timing with res_ready=1 and start sampled at edge k: tile n uses FETCH k+1+10n..k+4+10n, LOAD k+5+10n, COMPUTE k+6+10n..k+9+10n, WRITE k+10+10n. done is high in cycle k+10N+1 for N tiles.
- cfg_abort in any non-IDLE state: next state IDLE; same-edge outputs wmem_req, core_en, res_wr_en = 0; no done. A pending write is dropped.
- cfg_start while busy: ignored. Start and abort together in IDLE: start accepted.
- cfg_* inputs are sampled only at the accepted start; later changes do not affect the run.

Test Plan:
- base=0x000, num_tiles=1, mem rows 0..3 known, res_ready=1 -> wmem_addr 0,1,2,3 on cycles k+1..k+4; core_clr at k+5; core_en high k+6..k+9; res_wr_en at k+10, addr 0, data = golden psums; done at k+11.
- num_tiles=3, res_ready=1 -> 3 writes at res_wr_addr 0,1,2; done at k+31; busy high k+1..k+31.
- res_ready low for 5 cycles in tile 0 WRITE -> res_wr_en and res_wr_data stable for 6 cycles; tile 1 FETCH starts the cycle after accept; done delayed by 5.
- base=0x3FC, num_tiles=2 -> addresses 0x3FC..0x3FF, then 0x000..0x003.
- num_tiles=0 -> done at k+1, err=0, no wmem_req. num_tiles=17 -> done at k+1, err=1 held until next valid start.
- cfg_abort during COMPUTE of tile 1 -> core_en low next cycle, no further writes, no done. Then start with num_tiles=1 -> normal run. rst asserted mid-WRITE -> all outputs 0 next cycle.
